// File: rtl/polynomial_lms_trainer.sv
// ---------------------------------------------------------------------------
// polynomial_lms_trainer and the two single-issue IEEE-754 single-precision
// float cores it uses.
//
// floating_point_mult_valid_only / floating_point_add_valid_only
//   din_a, din_b, din_valid -> dout, dout_valid one cycle later.
//   Round-to-nearest-even. Subnormal inputs and results are flushed to zero.
//   NaN and Inf are propagated.
//
// polynomial_lms_trainer
//   For each sample pair (x, y) it computes est = sum taps[k]*x^k and
//   err = y - est. It then updates every tap with taps[k] += mu*err*x^k and
//   streams the updated taps out in index order. The error is sent last.
//   clk, reset    : clock, synchronous active-high reset (clears taps)
//   enable        : 0 abandons any sample in flight; taps are kept
//   din_*         : sample x, target y, step mu; valid/ready handshake
//   tap_wr_*      : updated tap index and value; valid/ready handshake
//   err_*         : error y - est; valid/ready handshake
// ---------------------------------------------------------------------------

module floating_point_mult_valid_only (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] din_a,
    input  logic [31:0] din_b,
    input  logic        din_valid,
    output logic [31:0] dout,
    output logic        dout_valid
);
    logic [31:0]       dout_q, dout_d;
    logic              dout_valid_q;
    logic              sign, nan_a, nan_b, inf_a, inf_b;
    logic [47:0]       prod;
    logic [22:0]       mant;
    logic [23:0]       mant_r;
    logic              guard, sticky;
    logic signed [9:0] exp_s;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        dout_d = 32'h0;
        prod   = '0;
        mant   = '0;
        mant_r = '0;
        guard  = 1'b0;
        sticky = 1'b0;
        exp_s  = '0;
        sign   = din_a[31] ^ din_b[31];
        nan_a  = (din_a[30:23] == 8'hFF) && (din_a[22:0] != '0);
        nan_b  = (din_b[30:23] == 8'hFF) && (din_b[22:0] != '0);
        inf_a  = (din_a[30:23] == 8'hFF) && (din_a[22:0] == '0);
        inf_b  = (din_b[30:23] == 8'hFF) && (din_b[22:0] == '0);
        if (nan_a || nan_b || (inf_a && din_b[30:23] == 8'h0) || (inf_b && din_a[30:23] == 8'h0)) begin
            dout_d = 32'h7FC0_0000;
        end else if (inf_a || inf_b) begin
            dout_d = {sign, 8'hFF, 23'h0};
        end else if (din_a[30:23] == 8'h0 || din_b[30:23] == 8'h0) begin
            dout_d = {sign, 31'h0};
        end else begin
            prod  = 48'({1'b1, din_a[22:0]}) * 48'({1'b1, din_b[22:0]});
            exp_s = $signed({2'b00, din_a[30:23]}) + $signed({2'b00, din_b[30:23]}) - 10'sd127;
            // Product of two [1,2) mantissas lies in [1,4): renormalise by one.
            if (prod[47]) begin
                mant   = prod[46:24];
                guard  = prod[23];
                sticky = |prod[22:0];
                exp_s  = exp_s + 10'sd1;
            end else begin
                mant   = prod[45:23];
                guard  = prod[22];
                sticky = |prod[21:0];
            end
            mant_r = {1'b0, mant} + {23'h0, guard & (sticky | mant[0])};
            if (mant_r[23]) exp_s = exp_s + 10'sd1;
            if (exp_s >= 10'sd255)   dout_d = {sign, 8'hFF, 23'h0};
            else if (exp_s <= 10'sd0) dout_d = {sign, 31'h0};
            else                      dout_d = {sign, exp_s[7:0], mant_r[22:0]};
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            dout_valid_q <= 1'b0;
            dout_q       <= 32'h0;
        end else begin
            dout_valid_q <= din_valid;
            if (din_valid) dout_q <= dout_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
endmodule

module floating_point_add_valid_only (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] din_a,
    input  logic [31:0] din_b,
    input  logic        din_valid,
    output logic [31:0] dout,
    output logic        dout_valid
);
    logic [31:0]       dout_q, dout_d;
    logic              dout_valid_q;
    logic              nan_a, nan_b, inf_a, inf_b, a_big, s_big, found;
    logic [7:0]        e_big, d;
    logic [49:0]       m_big, m_small, m_shift, sum, norm;
    logic [5:0]        lz;
    logic [22:0]       mant;
    logic [23:0]       mant_r;
    logic              guard, sticky;
    logic signed [9:0] exp_s;

    always_comb begin
        dout_d  = 32'h0;
        a_big   = din_a[30:0] >= din_b[30:0];
        s_big   = a_big ? din_a[31] : din_b[31];
        e_big   = a_big ? din_a[30:23] : din_b[30:23];
        d       = a_big ? din_a[30:23] - din_b[30:23] : din_b[30:23] - din_a[30:23];
        // Mantissas sit at bit 48 with 25 extra low bits for guard/sticky.
        m_big   = a_big ? {2'b01, din_a[22:0], 25'h0} : {2'b01, din_b[22:0], 25'h0};
        m_small = a_big ? {2'b01, din_b[22:0], 25'h0} : {2'b01, din_a[22:0], 25'h0};
        m_shift = '0;
        sum     = '0;
        norm    = '0;
        lz      = '0;
        found   = 1'b0;
        mant    = '0;
        mant_r  = '0;
        guard   = 1'b0;
        sticky  = 1'b0;
        exp_s   = '0;
        nan_a   = (din_a[30:23] == 8'hFF) && (din_a[22:0] != '0);
        nan_b   = (din_b[30:23] == 8'hFF) && (din_b[22:0] != '0);
        inf_a   = (din_a[30:23] == 8'hFF) && (din_a[22:0] == '0);
        inf_b   = (din_b[30:23] == 8'hFF) && (din_b[22:0] == '0);
        if (nan_a || nan_b || (inf_a && inf_b && din_a[31] != din_b[31])) begin
            dout_d = 32'h7FC0_0000;
        end else if (inf_a) begin
            dout_d = din_a;
        end else if (inf_b) begin
            dout_d = din_b;
        end else if (din_a[30:23] == 8'h0 && din_b[30:23] == 8'h0) begin
            dout_d = {din_a[31] & din_b[31], 31'h0};
        end else if (din_a[30:23] == 8'h0) begin
            dout_d = din_b;
        end else if (din_b[30:23] == 8'h0) begin
            dout_d = din_a;
        end else begin
            // Bits shifted out of the smaller operand collapse into a sticky bit.
            if (d > 8'd49) begin
                m_shift = 50'h1;
            end else begin
                m_shift = m_small >> d;
                if ((m_shift << d) != m_small) m_shift[0] = 1'b1;
            end
            sum = (din_a[31] == din_b[31]) ? m_big + m_shift : m_big - m_shift;
            if (sum == '0) begin
                dout_d = 32'h0;
            end else begin
                for (int i = 49; i >= 0; i--) begin
                    if (!found) begin
                        if (sum[i]) found = 1'b1;
                        else        lz    = lz + 6'd1;
                    end
                end
                norm   = sum << lz;
                exp_s  = $signed({2'b00, e_big}) + 10'sd1 - $signed({4'b0000, lz});
                mant   = norm[48:26];
                guard  = norm[25];
                sticky = |norm[24:0];
                mant_r = {1'b0, mant} + {23'h0, guard & (sticky | mant[0])};
                if (mant_r[23]) exp_s = exp_s + 10'sd1;
                if (exp_s >= 10'sd255)   dout_d = {s_big, 8'hFF, 23'h0};
                else if (exp_s <= 10'sd0) dout_d = {s_big, 31'h0};
                else                      dout_d = {s_big, exp_s[7:0], mant_r[22:0]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dout_valid_q <= 1'b0;
            dout_q       <= 32'h0;
        end else begin
            dout_valid_q <= din_valid;
            if (din_valid) dout_q <= dout_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
endmodule

module polynomial_lms_trainer #(
    parameter int G_POLY_ORDER = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [31:0] din_x,
    input  logic [31:0] din_target,
    input  logic [31:0] din_mu,
    input  logic        din_valid,
    output logic        din_ready,
    output logic [7:0]  tap_wr_addr,
    output logic [31:0] tap_wr_data,
    output logic        tap_wr_valid,
    input  logic        tap_wr_ready,
    output logic [31:0] err_out,
    output logic        err_valid,
    input  logic        err_ready
);
    localparam int KW = $clog2(G_POLY_ORDER);
    localparam logic [KW-1:0] K_LAST = KW'(G_POLY_ORDER - 1);
    localparam logic [31:0]   F_ONE  = 32'h3F80_0000;

    localparam logic [3:0] SM_INIT      = 4'd0;
    localparam logic [3:0] SM_GET_INPUT = 4'd1;
    localparam logic [3:0] SM_POW       = 4'd2;
    localparam logic [3:0] SM_PROD      = 4'd3;
    localparam logic [3:0] SM_ACC       = 4'd4;
    localparam logic [3:0] SM_ERR       = 4'd5;
    localparam logic [3:0] SM_DELTA     = 4'd6;
    localparam logic [3:0] SM_UPD       = 4'd7;
    localparam logic [3:0] SM_WRITE     = 4'd8;
    localparam logic [3:0] SM_SEND_ERR  = 4'd9;

    logic [3:0]    state_q, state_d;
    logic          busy_q, busy_d;          // one float op outstanding
    logic          err_phase_q, err_phase_d; // SM_ERR: 0 = subtract, 1 = scale by mu
    logic [KW-1:0] k_q, k_d;
    logic [31:0]   x_q, x_d, y_q, y_d, mu_q, mu_d;
    logic [31:0]   est_q, est_d, prod_q, prod_d, g_q, g_d, delta_q, delta_d;
    logic [31:0]   err_out_q, err_out_d, tap_wr_data_q, tap_wr_data_d;
    logic [7:0]    tap_wr_addr_q, tap_wr_addr_d;
    logic          tap_wr_valid_q, tap_wr_valid_d, err_valid_q, err_valid_d;
    logic          din_ready_q, din_ready_d;
    logic [31:0]   taps_q [G_POLY_ORDER];
    logic [31:0]   taps_d [G_POLY_ORDER];
    logic [31:0]   pows_q [G_POLY_ORDER];
    logic [31:0]   pows_d [G_POLY_ORDER];

    logic [31:0] mul_a, mul_b, mul_dout, add_a, add_b, add_dout;
    logic        mul_din_valid, mul_dout_valid, add_din_valid, add_dout_valid;
    logic        core_reset;

    // Flushing the cores on enable = 0 keeps an abandoned result from being
    // taken as the answer to a later op.
    assign core_reset = reset | ~enable;

    floating_point_mult_valid_only u_mult (
        .clk        (clk),
        .reset      (core_reset),
        .din_a      (mul_a),
        .din_b      (mul_b),
        .din_valid  (mul_din_valid),
        .dout       (mul_dout),
        .dout_valid (mul_dout_valid)
    );

    floating_point_add_valid_only u_add (
        .clk        (clk),
        .reset      (core_reset),
        .din_a      (add_a),
        .din_b      (add_b),
        .din_valid  (add_din_valid),
        .dout       (add_dout),
        .dout_valid (add_dout_valid)
    );

    always_comb begin
        state_d        = state_q;
        busy_d         = busy_q;
        err_phase_d    = err_phase_q;
        k_d            = k_q;
        x_d            = x_q;
        y_d            = y_q;
        mu_d           = mu_q;
        est_d          = est_q;
        prod_d         = prod_q;
        g_d            = g_q;
        delta_d        = delta_q;
        err_out_d      = err_out_q;
        tap_wr_addr_d  = tap_wr_addr_q;
        tap_wr_data_d  = tap_wr_data_q;
        tap_wr_valid_d = tap_wr_valid_q;
        err_valid_d    = err_valid_q;
        din_ready_d    = din_ready_q;
        taps_d         = taps_q;
        pows_d         = pows_q;
        mul_a          = '0;
        mul_b          = '0;
        mul_din_valid  = 1'b0;
        add_a          = '0;
        add_b          = '0;
        add_din_valid  = 1'b0;

        // Each op state issues once (busy low), then waits for the result.
        case (state_q)
            SM_INIT: begin
                din_ready_d = 1'b1;
                state_d     = SM_GET_INPUT;
            end
            SM_GET_INPUT: begin
                if (din_valid && din_ready_q) begin
                    x_d         = din_x;
                    y_d         = din_target;
                    mu_d        = din_mu;
                    din_ready_d = 1'b0;
                    pows_d[0]   = F_ONE;
                    est_d       = taps_q[0];
                    k_d         = KW'(1);
                    state_d     = SM_POW;
                end
            end
            SM_POW: begin
                mul_a         = pows_q[k_q - KW'(1)];
                mul_b         = x_q;
                mul_din_valid = ~busy_q;
                busy_d        = 1'b1;
                if (busy_q && mul_dout_valid) begin
                    busy_d      = 1'b0;
                    pows_d[k_q] = mul_dout;
                    state_d     = SM_PROD;
                end
            end
            SM_PROD: begin
                mul_a         = pows_q[k_q];
                mul_b         = taps_q[k_q];
                mul_din_valid = ~busy_q;
                busy_d        = 1'b1;
                if (busy_q && mul_dout_valid) begin
                    busy_d  = 1'b0;
                    prod_d  = mul_dout;
                    state_d = SM_ACC;
                end
            end
            SM_ACC: begin
                add_a         = est_q;
                add_b         = prod_q;
                add_din_valid = ~busy_q;
                busy_d        = 1'b1;
                if (busy_q && add_dout_valid) begin
                    busy_d = 1'b0;
                    est_d  = add_dout;
                    if (k_q == K_LAST) begin
                        err_phase_d = 1'b0;
                        state_d     = SM_ERR;
                    end else begin
                        k_d     = k_q + KW'(1);
                        state_d = SM_POW;
                    end
                end
            end
            SM_ERR: begin
                busy_d = 1'b1;
                if (!err_phase_q) begin
                    add_a         = y_q;
                    add_b         = {~est_q[31], est_q[30:0]};
                    add_din_valid = ~busy_q;
                    if (busy_q && add_dout_valid) begin
                        busy_d      = 1'b0;
                        err_out_d   = add_dout;
                        err_phase_d = 1'b1;
                    end
                end else begin
                    mul_a         = mu_q;
                    mul_b         = err_out_q;
                    mul_din_valid = ~busy_q;
                    if (busy_q && mul_dout_valid) begin
                        busy_d      = 1'b0;
                        g_d         = mul_dout;
                        err_phase_d = 1'b0;
                        k_d         = '0;
                        state_d     = SM_DELTA;
                    end
                end
            end
            SM_DELTA: begin
                mul_a         = g_q;
                mul_b         = pows_q[k_q];
                mul_din_valid = ~busy_q;
                busy_d        = 1'b1;
                if (busy_q && mul_dout_valid) begin
                    busy_d  = 1'b0;
                    delta_d = mul_dout;
                    state_d = SM_UPD;
                end
            end
            SM_UPD: begin
                add_a         = taps_q[k_q];
                add_b         = delta_q;
                add_din_valid = ~busy_q;
                busy_d        = 1'b1;
                if (busy_q && add_dout_valid) begin
                    busy_d         = 1'b0;
                    taps_d[k_q]    = add_dout;
                    tap_wr_addr_d  = 8'(k_q);
                    tap_wr_data_d  = add_dout;
                    tap_wr_valid_d = 1'b1;
                    state_d        = SM_WRITE;
                end
            end
            SM_WRITE: begin
                if (tap_wr_ready) begin
                    tap_wr_valid_d = 1'b0;
                    if (k_q == K_LAST) begin
                        err_valid_d = 1'b1;
                        state_d     = SM_SEND_ERR;
                    end else begin
                        k_d     = k_q + KW'(1);
                        state_d = SM_DELTA;
                    end
                end
            end
            SM_SEND_ERR: begin
                if (err_ready) begin
                    err_valid_d = 1'b0;
                    din_ready_d = 1'b1;
                    state_d     = SM_GET_INPUT;
                end
            end
            default: state_d = SM_INIT;
        endcase
    end

    // Control and datapath registers: enable = 0 behaves like reset here.
    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            state_q        <= SM_INIT;
            busy_q         <= 1'b0;
            err_phase_q    <= 1'b0;
            k_q            <= '0;
            x_q            <= '0;
            y_q            <= '0;
            mu_q           <= '0;
            est_q          <= '0;
            prod_q         <= '0;
            g_q            <= '0;
            delta_q        <= '0;
            err_out_q      <= '0;
            tap_wr_addr_q  <= '0;
            tap_wr_data_q  <= '0;
            tap_wr_valid_q <= 1'b0;
            err_valid_q    <= 1'b0;
            din_ready_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            busy_q         <= busy_d;
            err_phase_q    <= err_phase_d;
            k_q            <= k_d;
            x_q            <= x_d;
            y_q            <= y_d;
            mu_q           <= mu_d;
            est_q          <= est_d;
            prod_q         <= prod_d;
            g_q            <= g_d;
            delta_q        <= delta_d;
            err_out_q      <= err_out_d;
            tap_wr_addr_q  <= tap_wr_addr_d;
            tap_wr_data_q  <= tap_wr_data_d;
            tap_wr_valid_q <= tap_wr_valid_d;
            err_valid_q    <= err_valid_d;
            din_ready_q    <= din_ready_d;
        end
    end

    // Tap storage survives enable = 0; only reset clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the tap arrays are reset explicitly because training
            // must restart from all-zero coefficients, so they stay in flops.
            for (int i = 0; i < G_POLY_ORDER; i++) begin
                taps_q[i] <= '0;
                pows_q[i] <= '0;
            end
        end else if (enable) begin
            taps_q <= taps_d;
            pows_q <= pows_d;
        end
    end

    assign din_ready    = din_ready_q;
    assign tap_wr_addr  = tap_wr_addr_q;
    assign tap_wr_data  = tap_wr_data_q;
    assign tap_wr_valid = tap_wr_valid_q;
    assign err_out      = err_out_q;
    assign err_valid    = err_valid_q;
endmodule

// File: tb/tb_polynomial_lms_trainer.sv
// ---------------------------------------------------------------------------
// Directed bench for polynomial_lms_trainer with G_POLY_ORDER = 3.
// Expected tap and error values are hand-computed IEEE-754 constants.
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_polynomial_lms_trainer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b1;
    logic [31:0] din_x = '0;
    logic [31:0] din_target = '0;
    logic [31:0] din_mu = '0;
    logic        din_valid = 1'b0;
    logic        din_ready;
    logic [7:0]  tap_wr_addr;
    logic [31:0] tap_wr_data;
    logic        tap_wr_valid;
    logic        tap_wr_ready = 1'b1;
    logic [31:0] err_out;
    logic        err_valid;
    logic        err_ready = 1'b1;

    int vec_count  = 0;
    int miscompares = 0;

    localparam logic [31:0] F_0    = 32'h0000_0000;
    localparam logic [31:0] F_HALF = 32'h3F00_0000;
    localparam logic [31:0] F_1    = 32'h3F80_0000;
    localparam logic [31:0] F_2    = 32'h4000_0000;
    localparam logic [31:0] F_3P5  = 32'h4060_0000;

    polynomial_lms_trainer #(.G_POLY_ORDER(3)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .din_x        (din_x),
        .din_target   (din_target),
        .din_mu       (din_mu),
        .din_valid    (din_valid),
        .din_ready    (din_ready),
        .tap_wr_addr  (tap_wr_addr),
        .tap_wr_data  (tap_wr_data),
        .tap_wr_valid (tap_wr_valid),
        .tap_wr_ready (tap_wr_ready),
        .err_out      (err_out),
        .err_valid    (err_valid),
        .err_ready    (err_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_count++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_din_ready", 32'(din_ready), 32'd0);
        check("rst_wr_valid", 32'(tap_wr_valid), 32'd0);
        check("rst_err_valid", 32'(err_valid), 32'd0);
        check("rst_wr_addr", 32'(tap_wr_addr), 32'd0);
        check("rst_err_out", err_out, F_0);
        reset = 1'b0;
        @(negedge clk);
        check("init_din_ready", 32'(din_ready), 32'd1);
    endtask

    task automatic send_sample(input logic [31:0] x, input logic [31:0] y, input logic [31:0] mu);
        int n = 0;
        din_x      = x;
        din_target = y;
        din_mu     = mu;
        din_valid  = 1'b1;
        while (!din_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("accept", 32'(din_ready), 32'd1);
        @(negedge clk);
        din_valid = 1'b0;
    endtask

    task automatic expect_write(input int addr, input logic [31:0] data);
        int n = 0;
        while (!tap_wr_valid && n < 500) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("wr%0d_valid", addr), 32'(tap_wr_valid), 32'd1);
        check($sformatf("wr%0d_addr", addr), 32'(tap_wr_addr), 32'(addr));
        check($sformatf("wr%0d_data", addr), tap_wr_data, data);
        @(negedge clk);
    endtask

    task automatic expect_err(input logic [31:0] data);
        int n = 0;
        while (!err_valid && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("err_valid", 32'(err_valid), 32'd1);
        check("err_out", err_out, data);
        @(negedge clk);
    endtask

    task automatic run_sample(input logic [31:0] x, input logic [31:0] y, input logic [31:0] mu,
                              input logic [31:0] t0, input logic [31:0] t1, input logic [31:0] t2,
                              input logic [31:0] e);
        send_sample(x, y, mu);
        expect_write(0, t0);
        expect_write(1, t1);
        expect_write(2, t2);
        expect_err(e);
    endtask

    initial begin
        logic [31:0] a0, d0, e0;
        logic        ok_valid, ok_stable, ok_idle, ok_ready;
        int          n;

        @(negedge clk);
        apply_reset();

        // Taps 0, x = 2, y = 1, mu = 0.5: err = 1, taps become 0.5, 1, 2.
        run_sample(F_2, F_1, F_HALF, F_HALF, F_1, F_2, F_1);
        // x = 1, y = 3.5 matches est exactly: zero error, taps unchanged.
        run_sample(F_1, F_3P5, F_HALF, F_HALF, F_1, F_2, F_0);

        // x = 2, y = 1: est = 10.5, err = -9.5, taps -4.25, -8.5, -17.
        // Write 1 is held off for 20 cycles, then the error for 15 cycles.
        send_sample(F_2, F_1, F_HALF);
        expect_write(0, 32'hC088_0000);
        tap_wr_ready = 1'b0;
        n = 0;
        while (!tap_wr_valid && n < 500) begin
            @(negedge clk);
            n++;
        end
        a0 = 32'(tap_wr_addr);
        d0 = tap_wr_data;
        check("stall_addr", a0, 32'd1);
        check("stall_data", d0, 32'hC108_0000);
        ok_valid = 1'b1; ok_stable = 1'b1; ok_idle = 1'b1; ok_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!tap_wr_valid) ok_valid = 1'b0;
            if (32'(tap_wr_addr) != a0 || tap_wr_data != d0) ok_stable = 1'b0;
            if (dut.mul_din_valid || dut.add_din_valid) ok_idle = 1'b0;
            if (din_ready) ok_ready = 1'b0;
        end
        check("stall_valid_held", 32'(ok_valid), 32'd1);
        check("stall_stable", 32'(ok_stable), 32'd1);
        check("stall_no_ops", 32'(ok_idle), 32'd1);
        check("stall_din_ready_low", 32'(ok_ready), 32'd1);
        tap_wr_ready = 1'b1;
        @(negedge clk);
        expect_write(2, 32'hC188_0000);

        err_ready = 1'b0;
        n = 0;
        while (!err_valid && n < 500) begin
            @(negedge clk);
            n++;
        end
        e0 = err_out;
        check("hold_err_out", e0, 32'hC118_0000);
        // Offer the next pair (x = 1, y = -28.75) while the error is pending.
        din_x = F_1; din_target = 32'hC1E6_0000; din_mu = F_HALF; din_valid = 1'b1;
        ok_valid = 1'b1; ok_stable = 1'b1; ok_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (!err_valid) ok_valid = 1'b0;
            if (err_out != e0) ok_stable = 1'b0;
            if (din_ready) ok_ready = 1'b0;
        end
        check("hold_err_valid", 32'(ok_valid), 32'd1);
        check("hold_err_stable", 32'(ok_stable), 32'd1);
        check("hold_din_ready_low", 32'(ok_ready), 32'd1);
        err_ready = 1'b1;
        @(negedge clk);
        check("err_done", 32'(err_valid), 32'd0);
        check("ready_after_err", 32'(din_ready), 32'd1);
        @(negedge clk);
        din_valid = 1'b0;

        // est = -29.75, err = 1, g = 0.5: tap 0 -> -3.75, then enable drops
        // during the tap-1 delta multiply.
        expect_write(0, 32'hC070_0000);
        enable = 1'b0;
        @(negedge clk);
        check("dis_wr_valid", 32'(tap_wr_valid), 32'd0);
        check("dis_err_valid", 32'(err_valid), 32'd0);
        check("dis_din_ready", 32'(din_ready), 32'd0);
        @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        check("en_din_ready", 32'(din_ready), 32'd1);

        // mu = 0 writes the stored taps back unchanged: tap 0 updated, 1 and 2 old.
        // est = -29.25, y = 0 -> err = 29.25.
        run_sample(F_1, F_0, F_0, 32'hC070_0000, 32'hC108_0000, 32'hC188_0000, 32'h41EA_0000);

        // Reset clears taps: the first scenario repeats exactly.
        apply_reset();
        run_sample(F_2, F_1, F_HALF, F_HALF, F_1, F_2, F_1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
